// File: rtl/scie_fir_engine.sv
// Parametrised FIR engine behind the SCIE custom-instruction interface.
// Each PUSH runs a sequential MAC over all taps; READ returns saturated, low or high result words.
module scie_fir_engine #(
    parameter int XLEN   = 32,
    parameter int DATA_W = 32,
    parameter int COEF_W = 32,
    parameter int NTAPS  = 8,
    parameter int ACC_W  = 64,
    parameter int SHIFT  = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            io_valid,
    input  logic [31:0]     io_insn,
    input  logic [XLEN-1:0] io_rs1,
    input  logic [XLEN-1:0] io_rs2,
    output logic            io_ready,
    output logic [XLEN-1:0] io_rd,
    output logic            io_rd_valid
);

    localparam int IDX_W  = $clog2(NTAPS);
    localparam int WIDE_W = (ACC_W > 2 * XLEN) ? ACC_W : 2 * XLEN;

    localparam logic [6:0] OP_SETCOEF = 7'h0B;
    localparam logic [6:0] OP_PUSH    = 7'h2B;
    localparam logic [6:0] OP_READ    = 7'h5B;
    localparam logic [6:0] OP_CLEAR   = 7'h7B;

    // Handshake: a command transfers on any rising edge where io_valid && io_ready;
    // io_ready is low only while the MAC sequence runs, and refused commands are dropped.
    typedef enum logic {
        ST_IDLE,
        ST_MAC
    } state_t;

    state_t state, state_next;

    logic signed [COEF_W-1:0] coef [NTAPS];
    logic signed [DATA_W-1:0] hist [NTAPS];
    logic [IDX_W-1:0]         tap;
    logic signed [ACC_W-1:0]  acc, acc_sum, result, coef_ext, data_ext;
    logic signed [WIDE_W-1:0] res_wide, res_shift;
    logic [XLEN-WIDE_W+WIDE_W-1:0] rd_next;
    logic [WIDE_W-XLEN:0]     sat_hi;
    logic                     accept, last_tap, sat_fits;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic                     unused_bits;

    assign opcode      = io_insn[6:0];
    assign funct3      = io_insn[14:12];
    assign io_ready    = (state == ST_IDLE);
    assign accept      = io_valid && io_ready;
    assign last_tap    = (tap == IDX_W'(NTAPS - 1));
    assign unused_bits = ^{io_insn[31:15], io_insn[11:7], io_rs1, io_rs2, res_wide, res_shift};

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (io_valid && opcode == OP_PUSH) state_next = ST_MAC;
            ST_MAC:  if (last_tap) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        coef_ext = {{(ACC_W - COEF_W){coef[tap][COEF_W-1]}}, coef[tap]};
        data_ext = {{(ACC_W - DATA_W){hist[tap][DATA_W-1]}}, hist[tap]};
        acc_sum  = acc + coef_ext * data_ext;
    end

    // Result is sign-extended to at least 2*XLEN so every read view slices one vector.
    always_comb begin
        res_wide  = WIDE_W'(result);
        res_shift = res_wide >>> SHIFT;
        sat_hi    = res_shift[WIDE_W-1:XLEN-1];
        sat_fits  = (&sat_hi) || !(|sat_hi);
        rd_next   = '0;
        case (funct3)
            3'd0: begin
                if (sat_fits) rd_next = res_shift[XLEN-1:0];
                else if (res_shift[WIDE_W-1]) rd_next = {1'b1, {(XLEN - 1){1'b0}}};
                else rd_next = {1'b0, {(XLEN - 1){1'b1}}};
            end
            3'd1:    rd_next = res_wide[XLEN-1:0];
            3'd2:    rd_next = res_wide[2*XLEN-1:XLEN];
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                coef[k] <= '0;
                hist[k] <= '0;
            end
            tap         <= '0;
            acc         <= '0;
            result      <= '0;
            io_rd       <= '0;
            io_rd_valid <= 1'b0;
        end else begin
            io_rd_valid <= 1'b0;
            if (accept) begin
                case (opcode)
                    OP_SETCOEF: begin
                        if (io_rs2 < XLEN'(NTAPS)) coef[io_rs2[IDX_W-1:0]] <= io_rs1[COEF_W-1:0];
                    end
                    OP_PUSH: begin
                        for (int k = NTAPS - 1; k > 0; k--) hist[k] <= hist[k-1];
                        hist[0] <= io_rs1[DATA_W-1:0];
                        acc     <= '0;
                        tap     <= '0;
                    end
                    OP_READ: begin
                        io_rd       <= rd_next;
                        io_rd_valid <= 1'b1;
                    end
                    OP_CLEAR: begin
                        for (int k = 0; k < NTAPS; k++) hist[k] <= '0;
                        result <= '0;
                    end
                    default: ;
                endcase
            end
            if (state == ST_MAC) begin
                acc <= acc_sum;
                tap <= tap + IDX_W'(1);
                if (last_tap) result <= acc_sum;
            end
        end
    end

endmodule

// File: tb/tb_scie_fir_engine.sv
// Randomised scoreboard bench for scie_fir_engine (NTAPS=4) against a plain-arithmetic FIR model.
// Reads push expected words at accept; a negedge monitor pops them on every io_rd_valid pulse.
module tb_scie_fir_engine;

    localparam int NT = 4;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_valid = 1'b0;
    logic [31:0] io_insn = '0;
    logic [31:0] io_rs1 = '0;
    logic [31:0] io_rs2 = '0;
    logic        io_ready;
    logic [31:0] io_rd;
    logic        io_rd_valid;

    scie_fir_engine #(.NTAPS(NT)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_valid   (io_valid),
        .io_insn    (io_insn),
        .io_rs1     (io_rs1),
        .io_rs2     (io_rs2),
        .io_ready   (io_ready),
        .io_rd      (io_rd),
        .io_rd_valid(io_rd_valid)
    );

    // clock / reset
    always #5 clock = ~clock;

    // scoreboard state and reference model
    logic [31:0] exp_q[$];
    logic [31:0] mon_exp;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          coef_m[NT];
    int          hist_q[$];
    longint      result_m;
    logic [31:0] last_rd_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint fir_sum();
        longint s = 0;
        for (int k = 0; k < NT; k++) s += longint'(coef_m[k]) * longint'(hist_q[k]);
        return s;
    endfunction

    function automatic logic [31:0] model_read(input logic [2:0] f3);
        longint r = result_m;
        case (f3)
            3'd0: begin
                if (r > MAXV) return 32'h7FFF_FFFF;
                if (r < MINV) return 32'h8000_0000;
                return r[31:0];
            end
            3'd1:    return r[31:0];
            3'd2:    return r[63:32];
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NT; k++) coef_m[k] = 0;
        hist_q    = '{0, 0, 0, 0};
        result_m  = 0;
        last_rd_m = 0;
    endtask

    task automatic model_apply(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] rs1, input logic [31:0] rs2);
        case (op)
            7'h0B: if (rs2 < NT) coef_m[rs2] = int'(rs1);
            7'h2B: begin
                hist_q.push_front(int'(rs1));
                void'(hist_q.pop_back());
                result_m = fir_sum();
            end
            7'h5B: begin
                last_rd_m = model_read(f3);
                exp_q.push_back(last_rd_m);
            end
            7'h7B: begin
                hist_q   = '{0, 0, 0, 0};
                result_m = 0;
            end
            default: ;
        endcase
    endtask

    // driver tasks
    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] rs1,
                        input logic [31:0] rs2, output int waited);
        waited = 0;
        @(negedge clock);
        io_valid = 1'b1;
        io_insn  = {17'b0, f3, 5'b0, op};
        io_rs1   = rs1;
        io_rs2   = rs2;
        while (!io_ready && waited < 64) begin
            @(negedge clock);
            waited++;
        end
        if (!io_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL ready_timeout: io_ready stuck low for %0d cycles, required high", waited);
        end else begin
            model_apply(op, f3, rs1, rs2);
            @(posedge clock);
        end
        #1 io_valid = 1'b0;
    endtask

    task automatic setc(input logic [31:0] idx, input logic [31:0] val);
        int w;
        send(7'h0B, 3'd0, val, idx, w);
    endtask

    task automatic push(input logic [31:0] val);
        int w;
        send(7'h2B, 3'd0, val, 32'h0, w);
    endtask

    task automatic rd(input logic [2:0] f3);
        int w;
        send(7'h5B, f3, 32'h0, 32'h0, w);
    endtask

    task automatic clr();
        int w;
        send(7'h7B, 3'd0, 32'h0, 32'h0, w);
    endtask

    // monitor
    always @(negedge clock) begin
        if (!reset && io_rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_rd: pulse with io_rd=%h, required no pulse", io_rd);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_value", io_rd, mon_exp);
            end
            check("rd_pulse_while_busy", {31'b0, io_ready}, 32'h1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        logic [31:0] v, idx;
        logic [2:0]  f3;

        model_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_ready", {31'b0, io_ready}, 32'h1);
        check("reset_rd", io_rd, 32'h0);
        check("reset_rd_valid", {31'b0, io_rd_valid}, 32'h0);
        reset = 1'b0;

        rd(3'd0);

        // basic taps {1,2,3,4}: 10, 40, 100, 200
        for (int k = 0; k < NT; k++) setc(k, k + 1);
        for (int k = 1; k <= 4; k++) begin
            push(32'(10 * k));
            rd(3'd0);
        end

        // out-of-range coefficient writes are ignored
        setc(32'd4, 32'd99);
        setc(32'hFFFF_FFFF, 32'd99);
        push(32'd50);
        rd(3'd0);
        rd(3'd1);

        // clear keeps coefficients and io_rd holds its last value
        clr();
        @(negedge clock);
        check("rd_hold_after_clear", io_rd, last_rd_m);
        rd(3'd0);
        push(32'd5);
        rd(3'd0);

        // READ held while busy: accepted exactly NTAPS cycles later
        push(32'd6);
        send(7'h5B, 3'd0, 32'h0, 32'h0, w);
        check("busy_cycles", 32'(w), 32'(NT));

        // saturation and raw readback
        clr();
        setc(0, 32'h7FFF_FFFF);
        for (int k = 1; k < NT; k++) setc(k, 32'h0);
        push(32'h7FFF_FFFF);
        for (int k = 0; k < 4; k++) rd(3'(k));
        setc(0, 32'hFFFF_FFFF);
        push(32'd5);
        for (int k = 0; k < 3; k++) rd(3'(k));
        setc(0, 32'h8000_0000);
        push(32'h7FFF_FFFF);
        rd(3'd0);
        rd(3'd2);

        // randomised traffic
        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    idx = 32'($urandom_range(0, 5));
                    v   = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 40)) - 32'd20;
                    setc(idx, v);
                end
                2, 3, 4: begin
                    v = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 200)) - 32'd100;
                    push(v);
                end
                5, 6, 7: begin
                    f3 = 3'($urandom_range(0, 7));
                    rd(f3);
                end
                8: clr();
                default: send(7'h33, 3'($urandom_range(0, 7)), $urandom, $urandom, w);
            endcase
        end

        // reset in the middle of a MAC sequence
        clr();
        setc(0, 32'd3);
        push(32'd9);
        rd(3'd0);
        push(32'd11);
        @(negedge clock);
        @(negedge clock);
        check("busy_before_reset", {31'b0, io_ready}, 32'h0);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        check("midmac_reset_ready", {31'b0, io_ready}, 32'h1);
        check("midmac_reset_rd", io_rd, 32'h0);
        reset = 1'b0;
        rd(3'd0);
        push(32'd7);
        rd(3'd0);
        rd(3'd1);

        repeat (5) @(negedge clock);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
